// File: rtl/cim_xbar_tile.sv
// cim_xbar_tile
//   Binary-weight compute-in-memory crossbar tile. An input buffer of
//   xbar_size unsigned elements is multiplied against an xbar_size x xbar_size
//   array of 1-bit weights. Each COMPUTE cycle handles one row: ibuf[row] is
//   added into every column accumulator whose weight bit in that row is set.
//   A full matrix-vector multiply takes exactly xbar_size cycles. After the
//   run, column results are read back through a registered port.
//
// Ports
//   clk            single clock; all logic is on its rising edge
//   rst            asynchronous, active-low reset
//   i_cim_we       input-buffer write strobe (honoured only in IDLE)
//   i_cim_wr_addr  input-buffer row address
//   i_cim_data     unsigned input element
//   i_w_we         weight-row program strobe (honoured only in IDLE)
//   i_w_row        weight row address
//   i_w_data       one weight bit per column
//   i_start        MVM start pulse (honoured only in IDLE)
//   o_busy         high while computing
//   i_cim_rd_addr  result column select
//   o_data         registered column result, one cycle of read latency
//
// Configuration
//   CIM_XBAR_SAT_EN  when defined, results saturate at 2^datatype_size-1.
//                    When undefined, results are truncated to the low
//                    datatype_size bits.

module cim_xbar_tile #(
  parameter int xbar_size     = 128,
  parameter int datatype_size = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cim_we,
  input  logic [$clog2(xbar_size)-1:0] i_cim_wr_addr,
  input  logic [datatype_size-1:0]     i_cim_data,
  input  logic                         i_w_we,
  input  logic [$clog2(xbar_size)-1:0] i_w_row,
  input  logic [xbar_size-1:0]         i_w_data,
  input  logic                         i_start,
  output logic                         o_busy,
  input  logic [$clog2(xbar_size)-1:0] i_cim_rd_addr,
  output logic [datatype_size-1:0]     o_data
);

  localparam int acc_size = datatype_size + $clog2(xbar_size);
  localparam int addr_w   = $clog2(xbar_size);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COMPUTE = 1'b1;

  localparam logic [addr_w-1:0]   LAST_ROW = addr_w'(xbar_size - 1);
  localparam logic [acc_size-1:0] DATA_MAX = acc_size'((2 ** datatype_size) - 1);

  logic [0:0]               state_q, state_d;
  logic [addr_w-1:0]        row_q, row_d;
  logic [datatype_size-1:0] ibuf_q [xbar_size];
  logic [datatype_size-1:0] ibuf_d [xbar_size];
  logic [xbar_size-1:0]     w_q    [xbar_size];
  logic [xbar_size-1:0]     w_d    [xbar_size];
  logic [acc_size-1:0]      acc_q  [xbar_size];
  logic [acc_size-1:0]      acc_d  [xbar_size];
  logic [datatype_size-1:0] o_data_q, o_data_d;
  logic [datatype_size-1:0] rd_conv;

  // Next-state logic. Buffer and weight writes share the IDLE cycle with
  // i_start, so data written alongside a start is already in place when
  // row 0 is processed on the following cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ibuf_d  = ibuf_q;
    w_d     = w_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cim_we) ibuf_d[i_cim_wr_addr] = i_cim_data;
        if (i_w_we)   w_d[i_w_row]          = i_w_data;
        if (i_start) begin
          for (int c = 0; c < xbar_size; c++) acc_d[c] = '0;
          row_d   = '0;
          state_d = ST_COMPUTE;
        end
      end
      default: begin
        // acc_size is wide enough for xbar_size full-scale inputs, so the
        // add never overflows.
        for (int c = 0; c < xbar_size; c++) begin
          if (w_q[row_q][c]) acc_d[c] = acc_q[c] + acc_size'(ibuf_q[row_q]);
        end
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = ST_IDLE;
        end else begin
          row_d = row_q + addr_w'(1);
        end
      end
    endcase
  end

  // Result conversion and output register. o_data is forced to zero on the
  // start edge and throughout COMPUTE, so it reads zero for the whole busy
  // window.
  always_comb begin
`ifdef CIM_XBAR_SAT_EN
    rd_conv = (acc_q[i_cim_rd_addr] > DATA_MAX) ? '1
                                                : datatype_size'(acc_q[i_cim_rd_addr]);
`else
    rd_conv = datatype_size'(acc_q[i_cim_rd_addr]);
`endif
    o_data_d = ((state_q == ST_IDLE) && !i_start) ? rd_conv : '0;
  end

  // State registers. Reset clears all storage, including the weight array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      o_data_q <= '0;
      for (int i = 0; i < xbar_size; i++) begin
        ibuf_q[i] <= '0;
        w_q[i]    <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      o_data_q <= o_data_d;
      ibuf_q   <= ibuf_d;
      w_q      <= w_d;
      acc_q    <= acc_d;
    end
  end

  assign o_busy = (state_q == ST_COMPUTE);
  assign o_data = o_data_q;

endmodule

// File: tb/tb_cim_xbar_tile.sv
// tb_cim_xbar_tile
//   Randomised self-checking bench for cim_xbar_tile. A reference model keeps
//   the input buffer and weight matrix as plain arrays. It computes each
//   column result as the sum of ibuf[r] over the rows r whose weight bit is
//   set, then applies the configured saturation or truncation.

module tb_cim_xbar_tile;

  localparam int N  = 128;
  localparam int DW = 8;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cim_we;
  logic [AW-1:0] i_cim_wr_addr;
  logic [DW-1:0] i_cim_data;
  logic          i_w_we;
  logic [AW-1:0] i_w_row;
  logic [N-1:0]  i_w_data;
  logic          i_start;
  logic          o_busy;
  logic [AW-1:0] i_cim_rd_addr;
  logic [DW-1:0] o_data;

  always #5 clk = ~clk;

  cim_xbar_tile #(.xbar_size(N), .datatype_size(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cim_we      (i_cim_we),
    .i_cim_wr_addr (i_cim_wr_addr),
    .i_cim_data    (i_cim_data),
    .i_w_we        (i_w_we),
    .i_w_row       (i_w_row),
    .i_w_data      (i_w_data),
    .i_start       (i_start),
    .o_busy        (o_busy),
    .i_cim_rd_addr (i_cim_rd_addr),
    .o_data        (o_data)
  );

  // Reference model state
  int           ibuf_m  [N];
  logic [N-1:0] w_m     [N];
  longint       exp_acc [N];

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint convModel(input longint x);
`ifdef CIM_XBAR_SAT_EN
    return (x > 255) ? 255 : x;
`else
    return x % 256;
`endif
  endfunction

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin
      ibuf_m[i]  = 0;
      w_m[i]     = '0;
      exp_acc[i] = 0;
    end
  endtask

  task automatic computeGolden();
    for (int c = 0; c < N; c++) begin
      exp_acc[c] = 0;
      for (int r = 0; r < N; r++)
        if (w_m[r][c]) exp_acc[c] += longint'(ibuf_m[r]);
    end
  endtask

  task automatic writeIbuf(input int addr, input int data);
    i_cim_we      = 1'b1;
    i_cim_wr_addr = AW'(addr);
    i_cim_data    = DW'(data);
    @(negedge clk);
    i_cim_we      = 1'b0;
    ibuf_m[addr]  = data;
  endtask

  task automatic writeRow(input int row, input logic [N-1:0] data);
    i_w_we   = 1'b1;
    i_w_row  = AW'(row);
    i_w_data = data;
    @(negedge clk);
    i_w_we   = 1'b0;
    w_m[row] = data;
  endtask

  task automatic readCol(input int col, output longint val);
    i_cim_rd_addr = AW'(col);
    @(negedge clk);
    val = longint'(o_data);
  endtask

  task automatic checkCol(input string tag, input int col);
    longint v;
    readCol(col, v);
    checkOutput(tag, v, convModel(exp_acc[col]));
  endtask

  // Starts a run from the current negedge. It can optionally write ibuf[0]
  // in the same cycle as the start. It can also inject ignored writes and a
  // spurious start at busy cycle inject_at (pass -1 for none). It then checks
  // the busy length and that o_data stays zero while busy.
  task automatic applyStimulus(input bit sim_we, input int sim_data, input int inject_at);
    int busy_len;
    int nonzero;
    i_start = 1'b1;
    if (sim_we) begin
      i_cim_we      = 1'b1;
      i_cim_wr_addr = '0;
      i_cim_data    = DW'(sim_data);
      ibuf_m[0]     = sim_data;
    end
    computeGolden();
    @(negedge clk);
    i_start  = 1'b0;
    i_cim_we = 1'b0;
    busy_len = 0;
    nonzero  = 0;
    while (o_busy && busy_len < 4 * N) begin
      if (o_data != '0) nonzero++;
      if (busy_len == inject_at) begin
        i_cim_we      = 1'b1;
        i_cim_wr_addr = '0;
        i_cim_data    = DW'(99);
        i_w_we        = 1'b1;
        i_w_row       = '0;
        i_w_data      = '1;
        i_start       = 1'b1;
      end else begin
        i_cim_we = 1'b0;
        i_w_we   = 1'b0;
        i_start  = 1'b0;
      end
      busy_len++;
      @(negedge clk);
    end
    i_cim_we = 1'b0;
    i_w_we   = 1'b0;
    i_start  = 1'b0;
    checkOutput("busy_len", busy_len, N);
    checkOutput("busy_data_zero", nonzero, 0);
  endtask

  initial begin
    longint v;
    rst           = 1'b0;
    i_cim_we      = 1'b0;
    i_cim_wr_addr = '0;
    i_cim_data    = '0;
    i_w_we        = 1'b0;
    i_w_row       = '0;
    i_w_data      = '0;
    i_start       = 1'b0;
    i_cim_rd_addr = '0;
    clearModel();

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", longint'(o_busy), 0);
    checkOutput("reset_data", longint'(o_data), 0);
    rst = 1'b1;
    @(negedge clk);
    readCol(0, v);
    checkOutput("reset_col0", v, 0);

    // Basic MVM: rows 0 and 2 hit column 4 only
    writeIbuf(0, 3);
    writeIbuf(1, 5);
    writeIbuf(2, 7);
    writeRow(0, N'(1) << 4);
    writeRow(2, N'(1) << 4);
    applyStimulus(1'b0, 0, -1);
    readCol(4, v);
    checkOutput("basic_col4", v, 10);
    readCol(5, v);
    checkOutput("basic_col5", v, 0);

    // Random matrix and inputs
    for (int r = 0; r < N; r++) writeIbuf(r, int'($urandom_range(0, 255)));
    for (int r = 0; r < N; r++) writeRow(r, {$urandom, $urandom, $urandom, $urandom});
    applyStimulus(1'b0, 0, -1);
    checkCol("rand_col0", 0);
    checkCol("rand_colN", N - 1);
    for (int k = 0; k < 6; k++) checkCol("rand_col", int'($urandom_range(0, N - 1)));

    // Writes and start pulses during COMPUTE are ignored
    applyStimulus(1'b0, 0, 10);
    checkCol("ignored_col0", 0);
    checkCol("ignored_col7", 7);
    checkCol("ignored_rand", int'($urandom_range(0, N - 1)));

    // Back-to-back: second start lands on the cycle busy falls, with a
    // simultaneous ibuf[0] update; results must reflect only the second run
    applyStimulus(1'b0, 0, -1);
    applyStimulus(1'b1, int'($urandom_range(0, 255)), -1);
    checkCol("b2b_col0", 0);
    checkCol("b2b_col1", 1);
    checkCol("b2b_rand", int'($urandom_range(0, N - 1)));

    // Saturation / truncation: full-scale inputs and all-ones weights
    for (int r = 0; r < N; r++) writeIbuf(r, 255);
    for (int r = 0; r < N; r++) writeRow(r, '1);
    applyStimulus(1'b0, 0, -1);
    readCol(0, v);
`ifdef CIM_XBAR_SAT_EN
    checkOutput("sat_col0", v, 255);
`else
    checkOutput("trunc_col0", v, 128);
`endif

    // Reset during COMPUTE at row 40
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_busy", longint'(o_busy), 0);
    checkOutput("midrst_data", longint'(o_data), 0);
    clearModel();
    @(negedge clk);
    rst = 1'b1;
    readCol(0, v);
    checkOutput("midrst_col0", v, 0);
    checkOutput("midrst_busy_after", longint'(o_busy), 0);

    // Simultaneous ibuf write and start: weight[0][1] is the only set cell
    writeRow(0, N'(1) << 1);
    applyStimulus(1'b1, 9, -1);
    readCol(1, v);
    checkOutput("simul_col1", v, 9);
    readCol(0, v);
    checkOutput("simul_col0", v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cim_xbar_tile.md
CIM_XBAR_TILE -- requirements
Module: cim_xbar_tile

Interface
REQ-001 SHALL have parameter xbar_size, default 128, crossbar rows and columns.
REQ-002 SHALL have parameter datatype_size, default 8, input element and read-data width.
REQ-003 SHALL have local parameter acc_size = datatype_size + $clog2(xbar_size), column accumulator width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_cim_we, input, 1, input-buffer write strobe.
REQ-007 SHALL have port i_cim_wr_addr, input, $clog2(xbar_size), input-buffer row address.
REQ-008 SHALL have port i_cim_data, input, datatype_size, unsigned input element.
REQ-009 SHALL have port i_w_we, input, 1, weight-row program strobe.
REQ-010 SHALL have port i_w_row, input, $clog2(xbar_size), weight row address.
REQ-011 SHALL have port i_w_data, input, xbar_size, one 1-bit cell per column.
REQ-012 SHALL have port i_start, input, 1, MVM start pulse.
REQ-013 SHALL have port o_busy, output, 1, high while computing.
REQ-014 SHALL have port i_cim_rd_addr, input, $clog2(xbar_size), result column select.
REQ-015 SHALL have port o_data, output, datatype_size, registered column result.

Function
REQ-016 SHALL hold an input buffer of xbar_size x datatype_size, a weight array of xbar_size x xbar_size bits, and xbar_size accumulators of acc_size bits.
REQ-017 SHALL, in IDLE with i_cim_we=1, write i_cim_data to ibuf[i_cim_wr_addr] at that edge.
REQ-018 SHALL, in IDLE with i_w_we=1, write i_w_data to weight row i_w_row at that edge.
REQ-019 SHALL ignore i_cim_we, i_w_we and i_start while o_busy=1.
REQ-020 SHALL implement FSM states IDLE and COMPUTE.
REQ-021 SHALL, on i_start in IDLE, clear all accumulators, reset the row counter to 0, enter COMPUTE, and assert o_busy from the next cycle.
REQ-022 SHALL, in COMPUTE row r, for every column c with weight[r][c]=1, add ibuf[r] to acc[c], then increment r.
REQ-023 SHALL, after row xbar_size-1, return to IDLE with o_busy low, so o_busy is high for exactly xbar_size cycles.
REQ-024 SHALL make an i_cim_we or i_w_we in the same IDLE cycle as i_start take effect before row 0 is processed.
REQ-025 SHALL accumulate unsigned values without overflow, since acc_size bits hold the maximum sum.
REQ-026 SHALL, in IDLE, register o_data from conv(acc[i_cim_rd_addr]) with one cycle of read latency.
REQ-027 SHALL drive o_data to 0 while o_busy=1.
REQ-028 SHALL retain accumulators after COMPUTE until the next accepted i_start.

Reset
REQ-029 SHALL, on rst=0 at any time including mid-COMPUTE, immediately force IDLE, o_busy=0, o_data=0, row counter=0, all accumulators=0, all ibuf entries=0, and all weights=0.
REQ-030 SHALL resume accepting writes and i_start on the first clock edge after rst returns to 1.

Configuration
REQ-031 SHALL, with CIM_XBAR_SAT_EN defined, compute conv(x) = min(x, 2^datatype_size-1).
REQ-032 SHALL, without CIM_XBAR_SAT_EN, compute conv(x) = x[datatype_size-1:0] (truncation).

Verification
REQ-033 SHALL check reset: apply rst=0 mid-COMPUTE at row 40 -> o_busy=0 and o_data=0 immediately; a read of column 0 after release returns 0.
REQ-034 SHALL check basic MVM: ibuf[0..2]=3,5,7, weight rows 0 and 2 have only column 4 set, i_start -> o_busy high for 128 cycles; reading column 4 returns 10 one cycle later; column 5 returns 0.
REQ-035 SHALL check saturation: all ibuf=255, all weights=1 -> with CIM_XBAR_SAT_EN column 0 returns 255; without it, 32640 truncated returns 0x80.
REQ-036 SHALL check ignored inputs: during COMPUTE, write ibuf[0]=99, pulse i_w_we and i_start -> result unchanged from the golden value and busy length still 128.
REQ-037 SHALL check simultaneous events: i_cim_we (ibuf[0]=9) in the same cycle as i_start, weight[0][1]=1, other cells 0 -> column 1 returns 9.
REQ-038 SHALL check back-to-back: i_start the cycle o_busy falls -> a new 128-cycle run starts with accumulators cleared, and results reflect only the new run.
